// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore dispatcher: per-core status codes,
// controller state encoding and the supported core-count ceiling.
package multicore_pkg;

    localparam int NUM_CORES_MAX = 16;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_ACK   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/done_tracker.sv
// Sticky per-core completion flags. all_done also counts hits arriving this
// cycle, so a core finishing last is recognised without an extra cycle.
module done_tracker #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] hits,
    output logic         all_done
);

    logic [N-1:0] flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (clear) begin
            flags <= '0;
        end else if (enable) begin
            flags <= flags | (hits & mask);
        end
    end

    assign all_done = (((flags | hits) & mask) == mask);

endmodule

// File: rtl/multicore_dispatcher.sv
// Launch/collect controller for a group of processor cores.
// Optional watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module multicore_dispatcher
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16,
    parameter int TMO_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_CORES-1:0]   core_mask,
    input  logic                   abort,
    input  logic [TMO_W-1:0]       tmo_limit,
    input  logic [NUM_CORES-1:0]   core_end,
    output logic [2*NUM_CORES-1:0] core_status,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count
);

    state_t                 state, state_next;
    logic [NUM_CORES-1:0]   mask_q;
    logic                   all_done;
    logic                   accept;
    logic                   zero_start;
    logic                   zero_done_q;
    logic                   aborted_q;
    logic                   tmo_fire;
    logic                   in_run;

    assign accept     = (state == S_IDLE) && start && (core_mask != '0);
    assign zero_start = (state == S_IDLE) && start && (core_mask == '0);
    assign in_run     = (state == S_RUN);

    done_tracker #(.N(NUM_CORES)) u_done_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .enable   (in_run),
        .mask     (mask_q),
        .hits     (core_end),
        .all_done (all_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks completion, and completion outranks the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_START;
            S_START: state_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)         state_next = S_IDLE;
                else if (all_done) state_next = S_ACK;
                else if (tmo_fire) state_next = S_IDLE;
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        logic [1:0] code;
        code = ST_IDLE;
        case (state)
            S_START: code = ST_START;
            S_RUN:   code = ST_RUN;
            S_ACK:   code = ST_ACK;
            default: code = ST_IDLE;
        endcase
        core_status = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (mask_q[i]) core_status[2*i +: 2] = code;
        end
        busy    = (state != S_IDLE);
        done    = (state == S_ACK) || zero_done_q;
        aborted = aborted_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q      <= '0;
            cycle_count <= '0;
            zero_done_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            zero_done_q <= zero_start;
            aborted_q   <= ((state == S_START) && abort) ||
                           (in_run && (abort || (!all_done && tmo_fire)));
            if (accept) begin
                mask_q      <= core_mask;
                cycle_count <= '0;
            end else if (zero_start) begin
                cycle_count <= '0;
            end else if (in_run && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
    logic             timeout_q;

    assign tmo_next = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign tmo_fire = (tmo_limit != '0) && (tmo_next == tmo_limit);
    assign timeout  = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (in_run) begin
            tmo_cnt <= tmo_next;
            if (!abort && !all_done && tmo_fire) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_tmo_limit;

    assign unused_tmo_limit = ^tmo_limit;
    assign tmo_fire         = 1'b0;
    assign timeout          = 1'b0;
`endif

endmodule
